// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock divider and clock-enable generator.
// Produces a glitch-free divided clock (clk_out) straight from a flop, plus
// single-cycle strobes that fire the clka cycle before each clk_out edge.
// Optional feature macro: CLKGEN_RUNTIME_DIV_EN
//   defined   -> divide ratio can be reloaded through div_val/div_load/div_ack
//   undefined -> ratio fixed at DEFAULT_DIV, div_val/div_load ignored, div_ack=0
module clk_div_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clka,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             ce_rise,
  output logic             ce_fall,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic [WIDTH-1:0] n_cur;
  logic [WIDTH-1:0] low_len;
  logic             wrap;

  // Number of low cycles is ceil(N/2); computed one bit wider so N near the
  // top of the range cannot overflow the +1.
  assign low_len = WIDTH'(({1'b0, n_cur} + {{WIDTH{1'b0}}, 1'b1}) >> 1);
  assign wrap    = (cnt_q == (n_cur - ONE));

`ifdef CLKGEN_RUNTIME_DIV_EN
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;

  assign n_cur   = n_q;
  assign div_ack = ack_q;

  // Apply a pending ratio only on the wrap edge so the new period starts
  // cleanly at cnt=0; a load on that same edge becomes the next pending value.
  always_comb begin
    n_d        = n_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    if (enable && wrap && pend_q) begin
      n_d    = pend_val_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    if (div_load) begin
      pend_val_d = (div_val < TWO) ? TWO : div_val;
      pend_d     = 1'b1;
    end
  end

  // Ratio, pending-load and acknowledge registers.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      n_q        <= DEF_N;
      pend_val_q <= DEF_N;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      n_q        <= n_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
    end
  end
`else
  logic unused_load_inputs;

  assign n_cur              = DEF_N;
  assign div_ack            = 1'b0;
  assign unused_load_inputs = ^{div_val, div_load};
`endif

  // Phase counter and divided clock; clk_out is derived from the next count
  // so that clk_out == (cnt >= L) holds after every edge.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    if (enable) begin
      if (wrap) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      clk_out_d = (cnt_d >= low_len);
    end
  end

  // Counter and clock output flops.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign cnt     = cnt_q;
  assign clk_out = clk_out_q;
  assign ce_rise = enable & (cnt_q == (low_len - ONE));
  assign ce_fall = enable & wrap;

endmodule
